uart_tx_frame: RTL



---
 rtl/uart_tx_frame.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmitter with runtime framing and one-word holding buffer
// Optional break generation is enabled with `define UART_TX_BREAK_EN (adds input tx_break).
module uart_tx_frame #(
  parameter int NB_DATA = 8,
  parameter int SB_TICK = 16,
  parameter int NB_TCNT = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_tick,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NB_DATA-1:0] data_in,
  input  logic [3:0]         cfg_nbits,
  input  logic [1:0]         cfg_parity,
  input  logic               cfg_stop2,
`ifdef UART_TX_BREAK_EN
  input  logic               tx_break,
`endif
  output logic               tx_busy,
  output logic               tx_done_tick,
  output logic               tx_serial
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK, MAB} state_t;

  localparam logic [NB_TCNT-1:0] TICK_LAST = NB_TCNT'(SB_TICK - 1);
  localparam logic [3:0]         NB_MAX    = 4'(NB_DATA);

  state_t               state_q, state_d;
  logic [NB_TCNT-1:0]   tick_q, tick_d;
  logic [3:0]           bit_q, bit_d;
  logic [NB_DATA-1:0]   shift_q, shift_d;
  logic [NB_DATA-1:0]   buf_q, buf_d;
  logic                 buf_full_q, buf_full_d;
  logic [3:0]           nbits_q, nbits_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop2_q, stop2_d;
  logic                 tx_q, tx_d;

  logic                 bit_end;
  logic                 write;
  logic                 load;
  logic                 done_c;
  logic [3:0]           nbits_eff;
  logic [NB_DATA-1:0]   masked;
  logic                 par_new;

  assign bit_end      = s_tick && (tick_q == TICK_LAST);
  assign write        = in_valid && !buf_full_q;
  assign in_ready     = ~buf_full_q;
  assign tx_busy      = (state_q != IDLE);
  assign tx_serial    = tx_q;
  assign tx_done_tick = done_c & ~reset;

  // Framing is taken from the cfg inputs at load time, so parity is precomputed then too.
  always_comb begin
    nbits_eff = (cfg_nbits < 4'd5 || cfg_nbits > NB_MAX) ? NB_MAX : cfg_nbits;
    masked    = '0;
    for (int i = 0; i < NB_DATA; i++) begin
      masked[i] = buf_q[i] & (i < int'(nbits_eff));
    end
    par_new = (^masked) ^ (cfg_parity == 2'b10);
  end

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    load       = 1'b0;
    done_c     = 1'b0;

    if (state_q != IDLE && s_tick) begin
      tick_d = bit_end ? '0 : tick_q + NB_TCNT'(1);
    end

    case (state_q)
      IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (tx_break) begin
          state_d = BRK;
          tick_d  = '0;
        end else if (buf_full_q) begin
          load = 1'b1;
        end
`else
        if (buf_full_q) begin
          load = 1'b1;
        end
`endif
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == nbits_q - 4'd1) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_q == {3'b000, stop2_q}) begin
            done_c = 1'b1;
            if (buf_full_q) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = 4'd1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      BRK: begin
        tick_d = '0;
        if (!tx_break) begin
          state_d = MAB;
        end
      end
      MAB: begin
        if (bit_end) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d    = buf_q;
      nbits_d    = nbits_eff;
      par_en_d   = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
      par_bit_d  = par_new;
      stop2_d    = cfg_stop2;
      state_d    = START;
      tick_d     = '0;
      bit_d      = '0;
      buf_full_d = 1'b0;
    end
    if (write) begin
      buf_d      = data_in;
      buf_full_d = 1'b1;
    end
  end

  // The line is registered from the next state so it changes on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_d;
      BRK:     tx_d = 1'b0;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      nbits_q    <= NB_MAX;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      nbits_q    <= nbits_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
    end
  end

endmodule
